pwm_bank: RTL and testbench

Multi-channel PWM generator with one shared period counter and per-channel duty and phase offset. It is the parametrised successor to the fixed single-channel `pwm` instances. Duty and offset are double-buffered: shadow writes are committed to all channels together at a period boundary, so outputs never glitch mid-period. It sits between control logic (button handler, SPI register file) and board pins or LEDs.

---
 rtl/pwm_bank.sv | 141 ++++++++++++++
 tb/tb_pwm_bank.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_bank
//  Purpose  : Multi-channel PWM with a shared period counter, per-channel
//             duty/phase offset, and shadow registers committed at a wrap.
//             Optional PWM_BANK_GATE_EN adds gate_mask (out[k] &= raw[0]).
//  Revision : 1.0
// ============================================================================
module pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    period,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_duty,
    input  logic [WIDTH-1:0]    cfg_offset,
    input  logic                commit,
`ifdef PWM_BANK_GATE_EN
    input  logic [CHANNELS-1:0] gate_mask,
`endif
    output logic [CHANNELS-1:0] out,
    output logic                wrap
);

    localparam logic [CH_W:0]  c_CH_LIMIT = (CH_W+1)'(CHANNELS);
    localparam logic [WIDTH:0] c_PH_ONE   = (WIDTH+1)'(1);

    logic [WIDTH-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_per_a;
    logic                r_pending;
    logic [CHANNELS-1:0] r_out;
    logic                r_wrap;

    logic                w_at_end;
    logic                w_wr;
    logic                w_xfer;
    logic [CHANNELS-1:0] w_raw;
    logic [CHANNELS-1:0] w_gated;

    assign w_at_end  = (r_cnt == r_per_a);
    assign cfg_ready = ~r_pending;
    assign w_wr      = cfg_valid & cfg_ready & ({1'b0, cfg_ch} < c_CH_LIMIT);
    assign w_xfer    = w_at_end & r_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_per_a   <= '1;
            r_pending <= 1'b0;
        end else begin
            if (w_at_end) begin
                r_cnt   <= '0;
                r_per_a <= period;
            end else begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
            // A commit landing on the wrap itself waits for the next wrap.
            if (w_xfer) begin
                r_pending <= 1'b0;
            end else if (commit) begin
                r_pending <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [WIDTH-1:0] r_sh_duty;
        logic [WIDTH-1:0] r_sh_off;
        logic [WIDTH-1:0] r_duty_a;
        logic [WIDTH-1:0] r_off_a;
        logic [WIDTH-1:0] w_off_eff;
        logic [WIDTH:0]   w_ph;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sh_duty <= '0;
                r_sh_off  <= '0;
                r_duty_a  <= '0;
                r_off_a   <= '0;
            end else begin
                if (w_wr && (cfg_ch == CH_W'(k))) begin
                    r_sh_duty <= cfg_duty;
                    r_sh_off  <= cfg_offset;
                end
                if (w_xfer) begin
                    r_duty_a <= r_sh_duty;
                    r_off_a  <= r_sh_off;
                end
            end
        end

        // Phase is cnt shifted back by the offset, modulo the period length.
        always_comb begin
            w_off_eff = (r_off_a > r_per_a) ? '0 : r_off_a;
            if (r_cnt >= w_off_eff) begin
                w_ph = {1'b0, r_cnt} - {1'b0, w_off_eff};
            end else begin
                w_ph = {1'b0, r_cnt} + {1'b0, r_per_a} + c_PH_ONE - {1'b0, w_off_eff};
            end
        end

        assign w_raw[k] = (w_ph < {1'b0, r_duty_a});
    end

`ifdef PWM_BANK_GATE_EN
    logic w_unused_gate0;
    assign w_unused_gate0 = gate_mask[0];

    always_comb begin
        w_gated = w_raw;
        for (int k = 1; k < CHANNELS; k++) begin
            if (gate_mask[k]) begin
                w_gated[k] = w_raw[k] & w_raw[0];
            end
        end
    end
`else
    assign w_gated = w_raw;
`endif

    // The wrap pulse coincides with out reflecting cnt == 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_out  <= w_gated;
            r_wrap <= (r_cnt == '0);
        end
    end

    assign out  = r_out;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_pwm_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_bank
//  Purpose  : Directed scoreboard bench for pwm_bank; expected per-period
//             output patterns are queued and compared at each wrap.
//  Revision : 1.0
// ============================================================================
module tb_pwm_bank;

    localparam int CHANNELS = 4;
    localparam int WIDTH    = 8;
    localparam int CH_W     = 2;

`ifdef PWM_BANK_GATE_EN
    localparam logic [31:0] c_CH1_P9 = 32'h018;
`else
    localparam logic [31:0] c_CH1_P9 = 32'h0F8;
`endif

    typedef struct packed {
        int unsigned      len;
        logic [3:0][31:0] pat;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [WIDTH-1:0]    period = 8'd9;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_ch = '0;
    logic [WIDTH-1:0]    cfg_duty = '0;
    logic [WIDTH-1:0]    cfg_offset = '0;
    logic                commit = 1'b0;
    logic [CHANNELS-1:0] gate_mask = 4'b0010;
    logic [CHANNELS-1:0] out;
    logic                wrap;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pwm_bank #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .CH_W(CH_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .period     (period),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_duty   (cfg_duty),
        .cfg_offset (cfg_offset),
        .commit     (commit),
`ifdef PWM_BANK_GATE_EN
        .gate_mask  (gate_mask),
`endif
        .out        (out),
        .wrap       (wrap)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int unsigned len, input logic [31:0] p0, input logic [31:0] p1,
                            input logic [31:0] p2, input logic [31:0] p3);
        exp_t e;
        e.len    = len;
        e.pat[0] = p0;
        e.pat[1] = p1;
        e.pat[2] = p2;
        e.pat[3] = p3;
        exp_q.push_back(e);
    endtask

    task automatic wait_wrap(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = (wrap === 1'b1);
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got no wrap in 400 cycles, expected a wrap pulse", tag);
        end
    endtask

    task automatic wait_ready(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = (cfg_ready === 1'b1);
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got cfg_ready low for 400 cycles, expected it to return", tag);
        end
    endtask

    task automatic cfg_write(input int ch, input int duty, input int off, input bit with_commit);
        cfg_valid  = 1'b1;
        cfg_ch     = CH_W'(ch);
        cfg_duty   = WIDTH'(duty);
        cfg_offset = WIDTH'(off);
        commit     = with_commit;
        @(negedge clk);
        cfg_valid  = 1'b0;
        commit     = 1'b0;
    endtask

    // Monitor: one period (wrap to wrap) is captured per queued expectation.
    initial begin
        exp_t             e;
        bit               cap = 1'b0;
        int unsigned      n_s = 0;
        logic [3:0][31:0] got = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cap = 1'b0;
            end else begin
                if (cap && wrap) begin
                    e = exp_q.pop_front();
                    check("period_len", n_s, e.len);
                    for (int c = 0; c < CHANNELS; c++) begin
                        check($sformatf("pattern_ch%0d", c), got[c], e.pat[c]);
                    end
                    cap = 1'b0;
                end
                if (!cap && wrap && exp_q.size() > 0) begin
                    cap = 1'b1;
                    n_s = 0;
                    got = '0;
                end
                if (cap) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (n_s < 32) got[c][n_s] = out[c];
                    end
                    n_s++;
                end
            end
        end
    end

    initial begin
        bit              h1, h2, seen;
        logic [CHANNELS-1:0] acc;

        repeat (3) @(negedge clk);
        check("reset_out", 32'(out), 32'h0);
        check("reset_wrap", 32'(wrap), 32'h0);
        check("reset_ready", 32'(cfg_ready), 32'h1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Initial config; the last write carries the commit.
        cfg_write(1, 5, 3, 1'b0);
        cfg_write(2, 12, 0, 1'b0);
        cfg_write(3, 5, 15, 1'b0);
        cfg_write(0, 5, 0, 1'b1);
        check("ready_drop", 32'(cfg_ready), 32'h0);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;

        // Held write while pending: must wait for the transfer.
        cfg_valid  = 1'b1;
        cfg_ch     = 2'd2;
        cfg_duty   = 8'd0;
        cfg_offset = 8'd0;
        h1 = 1'b0;
        h2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (wrap === 1'b1) begin
                seen = 1'b1;
                cfg_valid = 1'b0;
            end else begin
                h2 = h1;
                h1 = cfg_ready;
            end
        end
        check("transfer_wrap_seen", 32'(seen), 32'h1);
        check("ready_at_wrap", 32'(cfg_ready), 32'h1);
        check("ready_low_while_pending", 32'(h2), 32'h0);
        cfg_valid = 1'b0;

        #1;
        push_exp(10, 32'h01F, c_CH1_P9, 32'h3FF, 32'h01F);
        push_exp(10, 32'h01F, c_CH1_P9, 32'h3FF, 32'h01F);
        repeat (3) wait_wrap("a_wrap");

        // ch2 already holds duty 0 from the held write.
        cfg_write(3, 12, 15, 1'b1);
        wait_ready("b_ready");
        wait_wrap("b_wrap");
        #1;
        push_exp(10, 32'h01F, c_CH1_P9, 32'h000, 32'h3FF);
        repeat (2) wait_wrap("b_drain");

        // Period 9 -> 4 mid-period: one 10-cycle period, then 5-cycle ones.
        wait_wrap("c_wrap0");
        #1;
        push_exp(10, 32'h01F, c_CH1_P9, 32'h000, 32'h3FF);
        push_exp(5, 32'h01F, 32'h01F, 32'h000, 32'h01F);
        push_exp(5, 32'h01F, 32'h01F, 32'h000, 32'h01F);
        wait_wrap("c_wrap1");
        repeat (3) @(negedge clk);
        period = 8'd4;
        repeat (3) wait_wrap("c_drain");
        period = 8'd9;
        repeat (2) wait_wrap("d_wrap");

        // Reset with cnt == 6 and a commit pending.
        cfg_write(0, 7, 0, 1'b1);
        repeat (4) @(negedge clk);
        check("d_ready_pending", 32'(cfg_ready), 32'h0);
        check("d_out_before", 32'(out), 32'({1'b1, 1'b0, c_CH1_P9[5], 1'b0}));
        #2 rst = 1'b1;
        #1;
        check("d_async_out", 32'(out), 32'h0);
        check("d_async_wrap", 32'(wrap), 32'h0);
        check("d_async_ready", 32'(cfg_ready), 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        acc = '0;
        repeat (300) begin
            @(negedge clk);
            acc |= out;
        end
        check("d_out_stays_low", 32'(acc), 32'h0);
        check("d_ready_after", 32'(cfg_ready), 32'h1);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
